stw_run_ctrl: RTL

- Mode controller for the stopwatch datapath. Turns debounced, one-pulsed button events (start/stop, lap, clear) into the sequencing signals for the time counters and the freeze (lap-hold) stage.
- Drives freeze_en directly into the freeze stage, and the count-enable and clear controls into the BCD time counters.
- Keeps a lap counter for the display.
- Sits between the button one-pulse logic and the counter/freeze/display datapath.

---
 rtl/stw_run_ctrl_if.sv | 26 ++
 rtl/stw_run_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/stw_run_ctrl_if.sv
// rtl/stw_run_ctrl_if.sv - button-event and counter-control bundle for stw_run_ctrl
// master drives the one-pulsed events; slave (the controller) drives the datapath controls.
interface stw_run_ctrl_if #(
  parameter int LAP_W = 4
);
  logic             tick;
  logic             start_stop_p;
  logic             lap_p;
  logic             clear_p;
  logic             count_en;
  logic             inc;
  logic             freeze_en;
  logic             cnt_clear;
  logic [LAP_W-1:0] lap_cnt;
  logic [2:0]       state;

  modport master (
    output tick, start_stop_p, lap_p, clear_p,
    input  count_en, inc, freeze_en, cnt_clear, lap_cnt, state
  );

  modport slave (
    input  tick, start_stop_p, lap_p, clear_p,
    output count_en, inc, freeze_en, cnt_clear, lap_cnt, state
  );
endinterface

// File: rtl/stw_run_ctrl.sv
// rtl/stw_run_ctrl.sv - stopwatch run/stop/lap mode controller, Moore FSM, all outputs registered
// Optional lap-freeze auto-release after LAP_HOLD_TICKS ticks: define STW_LAP_TIMEOUT_EN.
module stw_run_ctrl #(
  parameter int LAP_W          = 4,
  parameter int LAP_HOLD_TICKS = 5
) (
  input  logic           clk,
  input  logic           reset,
  stw_run_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    STOP     = 3'd2,
    LAP_RUN  = 3'd3,
    LAP_STOP = 3'd4
  } state_t;

  if (LAP_HOLD_TICKS < 1) begin : g_hold_chk
    $error("LAP_HOLD_TICKS must be at least 1");
  end

  state_t           state_q, state_d;
  logic             count_en_q, count_en_d;
  logic             freeze_en_q, freeze_en_d;
  logic             inc_q, inc_d;
  logic             cnt_clear_q, cnt_clear_d;
  logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;
  logic             timeout;

`ifdef STW_LAP_TIMEOUT_EN
  localparam int HOLD_W = $clog2(LAP_HOLD_TICKS + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;

  assign timeout = (hold_q == HOLD_W'(LAP_HOLD_TICKS));

  // Only a fresh lap (from RUN) restarts the hold; LAP_STOP merely pauses it.
  always_comb begin
    hold_d = hold_q;
    if (state_q == RUN && state_d == LAP_RUN) begin
      hold_d = '0;
    end else if (state_q == LAP_RUN && bus.tick && !timeout) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Events ignored in a state do not block lower-priority events.
  always_comb begin
    state_d     = state_q;
    cnt_clear_d = 1'b0;
    lap_cnt_d   = lap_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.clear_p) cnt_clear_d = 1'b1;
        else if (bus.start_stop_p) state_d = RUN;
      end
      RUN: begin
        if (bus.start_stop_p) begin
          state_d = STOP;
        end else if (bus.lap_p) begin
          state_d   = LAP_RUN;
          lap_cnt_d = lap_cnt_q + LAP_W'(1);
        end
      end
      STOP: begin
        if (bus.clear_p) begin
          state_d     = IDLE;
          cnt_clear_d = 1'b1;
        end else if (bus.start_stop_p) begin
          state_d = RUN;
        end
      end
      LAP_RUN: begin
        if (bus.start_stop_p) state_d = LAP_STOP;
        else if (bus.lap_p)   state_d = RUN;
        else if (timeout)     state_d = RUN;
      end
      LAP_STOP: begin
        if (bus.clear_p) begin
          state_d     = IDLE;
          cnt_clear_d = 1'b1;
        end else if (bus.start_stop_p) begin
          state_d = LAP_RUN;
        end else if (bus.lap_p) begin
          state_d = STOP;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_clear_d = 1'b1;
      end
    endcase
    if (cnt_clear_d) lap_cnt_d = '0;
    count_en_d  = (state_d == RUN) || (state_d == LAP_RUN);
    freeze_en_d = (state_d == LAP_RUN) || (state_d == LAP_STOP);
    inc_d       = bus.tick && ((state_q == RUN) || (state_q == LAP_RUN));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      count_en_q  <= 1'b0;
      freeze_en_q <= 1'b0;
      inc_q       <= 1'b0;
      cnt_clear_q <= 1'b0;
      lap_cnt_q   <= '0;
`ifdef STW_LAP_TIMEOUT_EN
      hold_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_en_q  <= count_en_d;
      freeze_en_q <= freeze_en_d;
      inc_q       <= inc_d;
      cnt_clear_q <= cnt_clear_d;
      lap_cnt_q   <= lap_cnt_d;
`ifdef STW_LAP_TIMEOUT_EN
      hold_q      <= hold_d;
`endif
    end
  end

  assign bus.state     = state_q;
  assign bus.count_en  = count_en_q;
  assign bus.freeze_en = freeze_en_q;
  assign bus.inc       = inc_q;
  assign bus.cnt_clear = cnt_clear_q;
  assign bus.lap_cnt   = lap_cnt_q;

endmodule
